// File: rtl/reorder_buffer_mp.sv
// Reorder buffer: circular queue with ALU/LSB write-back, operand lookup and in-order commit.
// Define ROB_DUAL_COMMIT_EN to retire up to two entries per cycle.
module reorder_buffer_mp #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    output logic             full_out,
    input  logic             issue_in,
    input  logic [6:0]       issue_opcode_in,
    input  logic [4:0]       issue_rd_in,
    input  logic [31:0]      issue_pc_in,
    input  logic [31:0]      issue_predict_pc_in,
    output logic [TAG_W-1:0] issue_tag_out,
    input  logic             wb0_valid_in,
    input  logic [TAG_W-1:0] wb0_tag_in,
    input  logic [31:0]      wb0_data_in,
    input  logic [31:0]      wb0_new_pc_in,
    input  logic             wb1_valid_in,
    input  logic [TAG_W-1:0] wb1_tag_in,
    input  logic [31:0]      wb1_data_in,
    input  logic [TAG_W-1:0] qj_tag_in,
    input  logic [TAG_W-1:0] qk_tag_in,
    output logic             qj_ready_out,
    output logic             qk_ready_out,
    output logic [31:0]      qj_data_out,
    output logic [31:0]      qk_data_out,
    output logic             commit0_valid_out,
    output logic [TAG_W-1:0] commit0_tag_out,
    output logic [4:0]       commit0_rd_out,
    output logic [31:0]      commit0_data_out,
    output logic             commit0_rf_we_out,
    output logic             commit0_store_out,
    output logic             commit1_valid_out,
    output logic [TAG_W-1:0] commit1_tag_out,
    output logic [4:0]       commit1_rd_out,
    output logic [31:0]      commit1_data_out,
    output logic             commit1_rf_we_out,
    output logic             commit1_store_out,
    output logic             flush_out,
    output logic [31:0]      flush_pc_out
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [IDX_W-1:0] head, tail, head1;
    logic [CNT_W-1:0] count, n_commit;
    logic [DEPTH-1:0] ready, occupied;
    logic [6:0]       opcode_mem  [DEPTH];
    logic [4:0]       rd_mem      [DEPTH];
    logic [31:0]      data_mem    [DEPTH];
    logic [31:0]      new_pc_mem  [DEPTH];
    logic [31:0]      predict_mem [DEPTH];

    logic wb0_go, wb1_go, issue_go, go0, go1, store0, ctl0, mispredict;
    logic unused_ok;
    logic [TAG_W-1:0] q_tag [2];
    logic [1:0]       q_ready;
    logic [31:0]      q_data [2];

    function automatic logic [IDX_W-1:0] tag_index(input logic [TAG_W-1:0] tag);
        return IDX_W'(tag - TAG_W'(1));
    endfunction

    function automatic logic tag_live(input logic [TAG_W-1:0] tag, input logic [DEPTH-1:0] occ);
        return (tag != '0) && (tag <= TAG_W'(DEPTH)) && occ[tag_index(tag)];
    endfunction

    assign unused_ok = ^{issue_pc_in, 1'b0};

    // An index is live when its distance from head is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = {1'b0, IDX_W'(i) - head} < count;
        end
    end

    assign full_out      = (count == CNT_W'(DEPTH));
    assign issue_tag_out = full_out ? '0 : TAG_W'(tail) + TAG_W'(1);
    assign wb0_go = wb0_valid_in && !flush_out && tag_live(wb0_tag_in, occupied);
    assign wb1_go = wb1_valid_in && !flush_out && tag_live(wb1_tag_in, occupied);

    assign q_tag[0] = qj_tag_in;
    assign q_tag[1] = qk_tag_in;

    // Operand lookup with same-cycle forwarding; ALU port has priority.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            q_ready[k] = 1'b0;
            q_data[k]  = '0;
            if (tag_live(q_tag[k], occupied)) begin
                if (wb0_go && (wb0_tag_in == q_tag[k])) begin
                    q_ready[k] = 1'b1;
                    q_data[k]  = wb0_data_in;
                end else if (wb1_go && (wb1_tag_in == q_tag[k])) begin
                    q_ready[k] = 1'b1;
                    q_data[k]  = wb1_data_in;
                end else begin
                    q_ready[k] = ready[tag_index(q_tag[k])];
                    q_data[k]  = data_mem[tag_index(q_tag[k])];
                end
            end
        end
    end

    assign qj_ready_out = q_ready[0];
    assign qk_ready_out = q_ready[1];
    assign qj_data_out  = q_data[0];
    assign qk_data_out  = q_data[1];

    assign head1      = head + IDX_W'(1);
    assign store0     = (opcode_mem[head] == OP_STORE);
    assign ctl0       = (opcode_mem[head] == OP_BRANCH) || (opcode_mem[head] == OP_JALR);
    assign go0        = (count != '0) && (ready[head] || store0);
    assign mispredict = go0 && ctl0 && (new_pc_mem[head] != predict_mem[head]);

`ifdef ROB_DUAL_COMMIT_EN
    logic store1, ctl1;
    assign store1 = (opcode_mem[head1] == OP_STORE);
    assign ctl1   = (opcode_mem[head1] == OP_BRANCH) || (opcode_mem[head1] == OP_JALR);
    // Redirects are only resolved in slot 0, so a control op in slot 1 waits a cycle.
    assign go1 = go0 && !ctl0 && !ctl1 && (count >= CNT_W'(2))
               && (ready[head1] || store1) && !(store0 && store1);
`else
    assign go1 = 1'b0;
`endif

    assign n_commit = CNT_W'(go0) + CNT_W'(go1);
    assign issue_go = issue_in && !full_out && !flush_out && !mispredict;

    // Entry payload storage; the ALU write is ordered last so it wins a tag collision.
    always_ff @(posedge clk) begin
        if (issue_go) begin
            opcode_mem[tail]  <= issue_opcode_in;
            rd_mem[tail]      <= issue_rd_in;
            predict_mem[tail] <= issue_predict_pc_in;
            new_pc_mem[tail]  <= issue_predict_pc_in;
        end
        if (wb1_go) begin
            data_mem[tag_index(wb1_tag_in)] <= wb1_data_in;
        end
        if (wb0_go) begin
            data_mem[tag_index(wb0_tag_in)]   <= wb0_data_in;
            new_pc_mem[tag_index(wb0_tag_in)] <= wb0_new_pc_in;
        end
    end

    // Queue pointers, ready bits, commit slots and redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0; tail <= '0; count <= '0; ready <= '0;
            commit0_valid_out <= 1'b0; commit0_tag_out <= '0; commit0_rd_out <= '0;
            commit0_data_out <= '0; commit0_rf_we_out <= 1'b0; commit0_store_out <= 1'b0;
            commit1_valid_out <= 1'b0; commit1_tag_out <= '0; commit1_rd_out <= '0;
            commit1_data_out <= '0; commit1_rf_we_out <= 1'b0; commit1_store_out <= 1'b0;
            flush_out <= 1'b0; flush_pc_out <= '0;
        end else begin
            commit0_valid_out <= go0;
            commit1_valid_out <= go1;
            flush_out         <= mispredict;
            if (go0) begin
                commit0_tag_out   <= TAG_W'(head) + TAG_W'(1);
                commit0_rd_out    <= rd_mem[head];
                commit0_data_out  <= data_mem[head];
                commit0_store_out <= store0;
                commit0_rf_we_out <= !store0 && (opcode_mem[head] != OP_BRANCH);
            end
            if (go1) begin
                commit1_tag_out   <= TAG_W'(head1) + TAG_W'(1);
                commit1_rd_out    <= rd_mem[head1];
                commit1_data_out  <= data_mem[head1];
                commit1_store_out <= (opcode_mem[head1] == OP_STORE);
                commit1_rf_we_out <= (opcode_mem[head1] != OP_STORE)
                                  && (opcode_mem[head1] != OP_BRANCH);
            end
            if (mispredict) begin
                flush_pc_out <= new_pc_mem[head];
            end
            if (issue_go) begin
                ready[tail] <= 1'b0;
            end
            if (wb1_go) begin
                ready[tag_index(wb1_tag_in)] <= 1'b1;
            end
            if (wb0_go) begin
                ready[tag_index(wb0_tag_in)] <= 1'b1;
            end
            if (mispredict) begin
                head  <= head1;
                tail  <= head1;
                count <= '0;
                ready <= '0;
            end else begin
                head  <= head + IDX_W'(n_commit);
                tail  <= tail + IDX_W'(issue_go);
                count <= count + CNT_W'(issue_go) - n_commit;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer_mp.sv
// Directed bench for reorder_buffer_mp (default DEPTH=16, TAG_W=5).
module tb_reorder_buffer_mp;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic        clk, rst, full_out, issue_in;
    logic [6:0]  issue_opcode_in;
    logic [4:0]  issue_rd_in;
    logic [31:0] issue_pc_in, issue_predict_pc_in;
    logic [4:0]  issue_tag_out;
    logic        wb0_valid_in, wb1_valid_in;
    logic [4:0]  wb0_tag_in, wb1_tag_in, qj_tag_in, qk_tag_in;
    logic [31:0] wb0_data_in, wb0_new_pc_in, wb1_data_in;
    logic        qj_ready_out, qk_ready_out;
    logic [31:0] qj_data_out, qk_data_out;
    logic        commit0_valid_out, commit0_rf_we_out, commit0_store_out;
    logic [4:0]  commit0_tag_out, commit0_rd_out;
    logic [31:0] commit0_data_out;
    logic        commit1_valid_out, commit1_rf_we_out, commit1_store_out;
    logic [4:0]  commit1_tag_out, commit1_rd_out;
    logic [31:0] commit1_data_out;
    logic        flush_out;
    logic [31:0] flush_pc_out;
    int checks, failures;

    reorder_buffer_mp dut (
        .clk(clk), .rst(rst), .full_out(full_out), .issue_in(issue_in),
        .issue_opcode_in(issue_opcode_in), .issue_rd_in(issue_rd_in),
        .issue_pc_in(issue_pc_in), .issue_predict_pc_in(issue_predict_pc_in),
        .issue_tag_out(issue_tag_out),
        .wb0_valid_in(wb0_valid_in), .wb0_tag_in(wb0_tag_in), .wb0_data_in(wb0_data_in),
        .wb0_new_pc_in(wb0_new_pc_in),
        .wb1_valid_in(wb1_valid_in), .wb1_tag_in(wb1_tag_in), .wb1_data_in(wb1_data_in),
        .qj_tag_in(qj_tag_in), .qk_tag_in(qk_tag_in),
        .qj_ready_out(qj_ready_out), .qk_ready_out(qk_ready_out),
        .qj_data_out(qj_data_out), .qk_data_out(qk_data_out),
        .commit0_valid_out(commit0_valid_out), .commit0_tag_out(commit0_tag_out),
        .commit0_rd_out(commit0_rd_out), .commit0_data_out(commit0_data_out),
        .commit0_rf_we_out(commit0_rf_we_out), .commit0_store_out(commit0_store_out),
        .commit1_valid_out(commit1_valid_out), .commit1_tag_out(commit1_tag_out),
        .commit1_rd_out(commit1_rd_out), .commit1_data_out(commit1_data_out),
        .commit1_rf_we_out(commit1_rf_we_out), .commit1_store_out(commit1_store_out),
        .flush_out(flush_out), .flush_pc_out(flush_pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        issue_in = 0; issue_opcode_in = '0; issue_rd_in = '0; issue_pc_in = '0;
        issue_predict_pc_in = '0; wb0_valid_in = 0; wb0_tag_in = '0; wb0_data_in = '0;
        wb0_new_pc_in = '0; wb1_valid_in = 0; wb1_tag_in = '0; wb1_data_in = '0;
        qj_tag_in = '0; qk_tag_in = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic issue(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] pred);
        issue_in = 1; issue_opcode_in = op; issue_rd_in = rd;
        issue_pc_in = pred - 32'd4; issue_predict_pc_in = pred;
        tick();
        issue_in = 0;
    endtask

    task automatic wb0(input logic [4:0] tag, input logic [31:0] data, input logic [31:0] npc);
        wb0_valid_in = 1; wb0_tag_in = tag; wb0_data_in = data; wb0_new_pc_in = npc;
        tick();
        wb0_valid_in = 0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks++; if (full_out !== 1'b0) begin failures++; $display("FAIL rst_full got=%0b exp=0", full_out); end
        checks++; if (issue_tag_out !== 5'd1) begin failures++; $display("FAIL rst_issue_tag got=%0d exp=1", issue_tag_out); end
        checks++; if ({commit0_valid_out, commit1_valid_out, flush_out} !== 3'b000) begin failures++; $display("FAIL rst_valids got=%b exp=000", {commit0_valid_out, commit1_valid_out, flush_out}); end
        qj_tag_in = 5'd1; #1;
        checks++; if (qj_ready_out !== 1'b0) begin failures++; $display("FAIL rst_lookup got=%0b exp=0", qj_ready_out); end
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            checks++; if (issue_tag_out !== 5'(i + 1)) begin failures++; $display("FAIL full_tag_seq got=%0d exp=%0d", issue_tag_out, i + 1); end
            issue(OP_ALU, 5'(i), 32'h0);
        end
        checks++; if (full_out !== 1'b1) begin failures++; $display("FAIL full_set got=%0b exp=1", full_out); end
        checks++; if (issue_tag_out !== 5'd0) begin failures++; $display("FAIL full_tag0 got=%0d exp=0", issue_tag_out); end
        issue(OP_ALU, 5'd17, 32'h0);
        checks++; if (full_out !== 1'b1 || issue_tag_out !== 5'd0) begin failures++; $display("FAIL full_17th got full=%0b tag=%0d exp full=1 tag=0", full_out, issue_tag_out); end
        qj_tag_in = 5'd16; #1;
        checks++; if (qj_ready_out !== 1'b0 || commit0_valid_out !== 1'b0) begin failures++; $display("FAIL full_no_commit got ready=%0b c0=%0b exp 0 0", qj_ready_out, commit0_valid_out); end
    endtask

    task automatic test_commit_order;
        do_reset();
        issue(OP_ALU, 5'd1, 32'h0);
        issue(OP_ALU, 5'd2, 32'h0);
        wb0_valid_in = 1; wb0_tag_in = 5'd2; wb0_data_in = 32'h55; qj_tag_in = 5'd2; #1;
        checks++; if (qj_ready_out !== 1'b1 || qj_data_out !== 32'h55) begin failures++; $display("FAIL order_fwd got r=%0b d=%h exp r=1 d=55", qj_ready_out, qj_data_out); end
        tick();
        wb0(5'd1, 32'h11, 32'h0);
        checks++; if (commit0_valid_out !== 1'b0) begin failures++; $display("FAIL order_latency got=%0b exp=0", commit0_valid_out); end
        tick();
        checks++; if (commit0_valid_out !== 1'b1 || commit0_tag_out !== 5'd1 || commit0_data_out !== 32'h11) begin failures++; $display("FAIL order_c0 got v=%0b t=%0d d=%h exp v=1 t=1 d=11", commit0_valid_out, commit0_tag_out, commit0_data_out); end
        checks++; if (commit0_rd_out !== 5'd1 || commit0_rf_we_out !== 1'b1 || commit0_store_out !== 1'b0 || flush_out !== 1'b0) begin failures++; $display("FAIL order_c0_fields got rd=%0d we=%0b st=%0b fl=%0b exp 1 1 0 0", commit0_rd_out, commit0_rf_we_out, commit0_store_out, flush_out); end
`ifdef ROB_DUAL_COMMIT_EN
        checks++; if (commit1_valid_out !== 1'b1 || commit1_tag_out !== 5'd2 || commit1_data_out !== 32'h55) begin failures++; $display("FAIL order_c1 got v=%0b t=%0d d=%h exp v=1 t=2 d=55", commit1_valid_out, commit1_tag_out, commit1_data_out); end
`else
        checks++; if (commit1_valid_out !== 1'b0) begin failures++; $display("FAIL order_c1_off got=%0b exp=0", commit1_valid_out); end
        tick();
        checks++; if (commit0_valid_out !== 1'b1 || commit0_tag_out !== 5'd2 || commit0_data_out !== 32'h55) begin failures++; $display("FAIL order_c0_second got v=%0b t=%0d d=%h exp v=1 t=2 d=55", commit0_valid_out, commit0_tag_out, commit0_data_out); end
`endif
        tick();
        checks++; if (commit0_valid_out !== 1'b0 || commit1_valid_out !== 1'b0 || issue_tag_out !== 5'd3) begin failures++; $display("FAIL order_drain got c0=%0b c1=%0b tag=%0d exp 0 0 3", commit0_valid_out, commit1_valid_out, issue_tag_out); end
    endtask

    task automatic test_flush;
        do_reset();
        issue(OP_BRANCH, 5'd0, 32'h100);
        wb0(5'd1, 32'h0, 32'h200);
        checks++; if (commit0_valid_out !== 1'b0 || flush_out !== 1'b0) begin failures++; $display("FAIL flush_early got c0=%0b fl=%0b exp 0 0", commit0_valid_out, flush_out); end
        tick();
        checks++; if (commit0_valid_out !== 1'b1 || commit0_tag_out !== 5'd1 || commit0_rf_we_out !== 1'b0) begin failures++; $display("FAIL flush_commit got v=%0b t=%0d we=%0b exp 1 1 0", commit0_valid_out, commit0_tag_out, commit0_rf_we_out); end
        checks++; if (flush_out !== 1'b1 || flush_pc_out !== 32'h200) begin failures++; $display("FAIL flush_redirect got fl=%0b pc=%h exp 1 200", flush_out, flush_pc_out); end
        checks++; if (issue_tag_out !== 5'd2 || full_out !== 1'b0) begin failures++; $display("FAIL flush_empty got tag=%0d full=%0b exp 2 0", issue_tag_out, full_out); end
        issue_in = 1; issue_opcode_in = OP_ALU; wb0_valid_in = 1; wb0_tag_in = 5'd2;
        tick();
        idle_inputs();
        qj_tag_in = 5'd2; #1;
        checks++; if (flush_out !== 1'b0 || commit0_valid_out !== 1'b0) begin failures++; $display("FAIL flush_one_cycle got fl=%0b c0=%0b exp 0 0", flush_out, commit0_valid_out); end
        checks++; if (issue_tag_out !== 5'd2 || qj_ready_out !== 1'b0) begin failures++; $display("FAIL flush_issue_ignored got tag=%0d r=%0b exp 2 0", issue_tag_out, qj_ready_out); end
        issue(OP_BRANCH, 5'd0, 32'h300);
        wb0(5'd2, 32'h0, 32'h300);
        tick();
        checks++; if (commit0_valid_out !== 1'b1 || commit0_tag_out !== 5'd2 || flush_out !== 1'b0) begin failures++; $display("FAIL flush_correct got v=%0b t=%0d fl=%0b exp 1 2 0", commit0_valid_out, commit0_tag_out, flush_out); end
        issue(OP_JALR, 5'd5, 32'h400);
        wb0(5'd3, 32'h1234, 32'h500);
        tick();
        checks++; if (commit0_valid_out !== 1'b1 || commit0_rf_we_out !== 1'b1 || commit0_rd_out !== 5'd5 || commit0_data_out !== 32'h1234) begin failures++; $display("FAIL flush_jalr_commit got v=%0b we=%0b rd=%0d d=%h exp 1 1 5 1234", commit0_valid_out, commit0_rf_we_out, commit0_rd_out, commit0_data_out); end
        checks++; if (flush_out !== 1'b1 || flush_pc_out !== 32'h500) begin failures++; $display("FAIL flush_jalr got fl=%0b pc=%h exp 1 500", flush_out, flush_pc_out); end
    endtask

    task automatic test_wb_priority;
        do_reset();
        issue(OP_ALU, 5'd1, 32'h0);
        issue(OP_ALU, 5'd2, 32'h0);
        issue(OP_ALU, 5'd3, 32'h0);
        wb0_valid_in = 1; wb0_tag_in = 5'd3; wb0_data_in = 32'hA;
        wb1_valid_in = 1; wb1_tag_in = 5'd3; wb1_data_in = 32'hB;
        qj_tag_in = 5'd3; qk_tag_in = 5'd5; #1;
        checks++; if (qj_ready_out !== 1'b1 || qj_data_out !== 32'hA) begin failures++; $display("FAIL prio_fwd got r=%0b d=%h exp 1 a", qj_ready_out, qj_data_out); end
        checks++; if (qk_ready_out !== 1'b0) begin failures++; $display("FAIL prio_unocc got=%0b exp=0", qk_ready_out); end
        tick();
        idle_inputs();
        qj_tag_in = 5'd3; #1;
        checks++; if (qj_ready_out !== 1'b1 || qj_data_out !== 32'hA) begin failures++; $display("FAIL prio_stored got r=%0b d=%h exp 1 a", qj_ready_out, qj_data_out); end
        wb1_valid_in = 1; wb1_tag_in = 5'd2; wb1_data_in = 32'hB;
        wb0_valid_in = 1; wb0_tag_in = 5'd5; wb0_data_in = 32'hC;
        qk_tag_in = 5'd2; qj_tag_in = 5'd5; #1;
        checks++; if (qk_ready_out !== 1'b1 || qk_data_out !== 32'hB) begin failures++; $display("FAIL prio_wb1_fwd got r=%0b d=%h exp 1 b", qk_ready_out, qk_data_out); end
        checks++; if (qj_ready_out !== 1'b0) begin failures++; $display("FAIL prio_wb_unocc got=%0b exp=0", qj_ready_out); end
        tick();
        idle_inputs();
        qk_tag_in = 5'd2; qj_tag_in = 5'd1; #1;
        checks++; if (qk_ready_out !== 1'b1 || qk_data_out !== 32'hB || qj_ready_out !== 1'b0) begin failures++; $display("FAIL prio_after got qk=%0b/%h qj=%0b exp 1/b 0", qk_ready_out, qk_data_out, qj_ready_out); end
        qj_tag_in = 5'd0; #1;
        checks++; if (qj_ready_out !== 1'b0 || commit0_valid_out !== 1'b0) begin failures++; $display("FAIL prio_null got r=%0b c0=%0b exp 0 0", qj_ready_out, commit0_valid_out); end
    endtask

    task automatic test_wrap_stores;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            checks++; if (issue_tag_out !== 5'((i % 16) + 1)) begin failures++; $display("FAIL wrap_tag i=%0d got=%0d exp=%0d", i, issue_tag_out, (i % 16) + 1); end
            issue(OP_ALU, 5'(i), 32'h0);
            wb0(5'((i % 16) + 1), 32'(i), 32'h0);
            tick();
            checks++; if (commit0_valid_out !== 1'b1 || commit0_tag_out !== 5'((i % 16) + 1) || commit0_data_out !== 32'(i)) begin failures++; $display("FAIL wrap_commit i=%0d got v=%0b t=%0d d=%0d exp v=1 t=%0d d=%0d", i, commit0_valid_out, commit0_tag_out, commit0_data_out, (i % 16) + 1, i); end
        end
        issue(OP_ALU, 5'd9, 32'h0);
        issue(OP_STORE, 5'd0, 32'h0);
        issue(OP_STORE, 5'd0, 32'h0);
        checks++; if (commit0_valid_out !== 1'b0) begin failures++; $display("FAIL st_blocked got=%0b exp=0", commit0_valid_out); end
        wb0(5'd9, 32'h99, 32'h0);
        tick();
        checks++; if (commit0_valid_out !== 1'b1 || commit0_tag_out !== 5'd9 || commit0_data_out !== 32'h99) begin failures++; $display("FAIL st_alu got v=%0b t=%0d d=%h exp 1 9 99", commit0_valid_out, commit0_tag_out, commit0_data_out); end
`ifdef ROB_DUAL_COMMIT_EN
        checks++; if (commit1_valid_out !== 1'b1 || commit1_tag_out !== 5'd10 || commit1_store_out !== 1'b1 || commit1_rf_we_out !== 1'b0) begin failures++; $display("FAIL st_pair got v=%0b t=%0d st=%0b we=%0b exp 1 10 1 0", commit1_valid_out, commit1_tag_out, commit1_store_out, commit1_rf_we_out); end
        tick();
        checks++; if (commit0_valid_out !== 1'b1 || commit0_tag_out !== 5'd11 || commit0_store_out !== 1'b1 || commit1_valid_out !== 1'b0) begin failures++; $display("FAIL st_second got v=%0b t=%0d st=%0b c1=%0b exp 1 11 1 0", commit0_valid_out, commit0_tag_out, commit0_store_out, commit1_valid_out); end
`else
        checks++; if (commit1_valid_out !== 1'b0) begin failures++; $display("FAIL st_c1_off got=%0b exp=0", commit1_valid_out); end
        tick();
        checks++; if (commit0_valid_out !== 1'b1 || commit0_tag_out !== 5'd10 || commit0_store_out !== 1'b1 || commit0_rf_we_out !== 1'b0) begin failures++; $display("FAIL st_first got v=%0b t=%0d st=%0b we=%0b exp 1 10 1 0", commit0_valid_out, commit0_tag_out, commit0_store_out, commit0_rf_we_out); end
        tick();
        checks++; if (commit0_valid_out !== 1'b1 || commit0_tag_out !== 5'd11 || commit0_store_out !== 1'b1) begin failures++; $display("FAIL st_second got v=%0b t=%0d st=%0b exp 1 11 1", commit0_valid_out, commit0_tag_out, commit0_store_out); end
`endif
        tick();
        checks++; if (commit0_valid_out !== 1'b0 || commit1_valid_out !== 1'b0 || issue_tag_out !== 5'd12) begin failures++; $display("FAIL st_drain got c0=%0b c1=%0b tag=%0d exp 0 0 12", commit0_valid_out, commit1_valid_out, issue_tag_out); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        issue(OP_ALU, 5'd1, 32'h0);
        wb0(5'd1, 32'h7, 32'h0);
        rst = 1;
        tick();
        rst = 0;
        checks++; if (commit0_valid_out !== 1'b0 || issue_tag_out !== 5'd1) begin failures++; $display("FAIL rstmid_commit got c0=%0b tag=%0d exp 0 1", commit0_valid_out, issue_tag_out); end
        tick();
        checks++; if (commit0_valid_out !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%0b exp=0", commit0_valid_out); end
        issue(OP_BRANCH, 5'd0, 32'h100);
        wb0(5'd1, 32'h0, 32'h200);
        rst = 1;
        tick();
        rst = 0;
        tick();
        checks++; if (flush_out !== 1'b0 || commit0_valid_out !== 1'b0 || issue_tag_out !== 5'd1) begin failures++; $display("FAIL rstmid_flush got fl=%0b c0=%0b tag=%0d exp 0 0 1", flush_out, commit0_valid_out, issue_tag_out); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_full();
        test_commit_order();
        test_flush();
        test_wb_priority();
        test_wrap_stores();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reorder_buffer_mp.md
REORDER_BUFFER_MP -- requirements
Module: reorder_buffer_mp

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the entry count (power of two, 4..64); entry tags are 1..DEPTH, and tag 0 is NULL.
REQ-002 The block SHALL have parameter TAG_W, default 5, meaning the tag width; it SHALL satisfy 2^TAG_W > DEPTH.
REQ-003 clk  in  1  clock, single domain; one clock, synchronous active-high reset.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 full_out  out  1  combinational; high when count==DEPTH.
REQ-006 issue_in  in  1  allocate one entry this cycle.
REQ-007 issue_opcode_in / issue_rd_in / issue_pc_in / issue_predict_pc_in  in  7/5/32/32  new entry fields.
REQ-008 issue_tag_out  out  TAG_W  combinational; tag the next allocation gets, or 0 when full.
REQ-009 wbK_valid_in / wbK_tag_in / wbK_data_in, K=0,1  in  1/TAG_W/32  two result buses; K=0 is ALU, K=1 is LSB.
REQ-010 wb0_new_pc_in  in  32  resolved next PC for the ALU result.
REQ-011 qj_tag_in, qk_tag_in  in  TAG_W  operand lookup tags.
REQ-012 qj_ready_out, qk_ready_out / qj_data_out, qk_data_out  out  1/32  combinational operand lookup results.
REQ-013 commitK_valid_out / _tag_out / _rd_out / _data_out / _rf_we_out / _store_out, K=0,1  out  1/TAG_W/5/32/1/1  registered commit slots.
REQ-014 flush_out / flush_pc_out  out  1/32  registered mispredict redirect.

Function
REQ-015 Storage SHALL be a circular queue with head (oldest), tail (next free) and count; both pointers SHALL wrap DEPTH-1 -> 0; tag = index+1.
REQ-016 issue_in with !full_out SHALL write the entry at tail with ready=0 and advance tail; issue_in while full SHALL be ignored with no state change.
REQ-017 A write-back SHALL set data, ready (and new_pc, port 0 only) when its tag != 0 and is occupied; other tags SHALL be ignored.
REQ-018 When both write-back ports carry the same tag in one cycle, port 0 SHALL win.
REQ-019 A lookup SHALL report ready=1 when the tag is occupied and ready, or when it matches a valid write-back this cycle; the write-back data SHALL then be forwarded, with port 0 having priority.
REQ-020 A lookup with tag 0 or an unoccupied tag SHALL return ready=0.
REQ-021 Head is committable when it is ready or its opcode is STORE; commit outputs SHALL assert on the edge after the head becomes committable (1-cycle latency).
REQ-022 rf_we SHALL be 1 unless the opcode is BRANCH or STORE; store SHALL be 1 only for STORE; rd, data and tag SHALL be copied from the entry.
REQ-023 Slot 1 SHALL commit only if slot 0 commits; slot 0 is not BRANCH/JALR; head+1 is occupied and committable; and at most one STORE is in the pair.
REQ-024 Issue and commit in the same cycle SHALL both take effect, and count SHALL change by issued-committed; full with simultaneous commit+issue SHALL remain consistent.
REQ-025 When slot 0 commits a BRANCH or JALR with new_pc != predict_pc, the same edge SHALL assert flush_out=1 with flush_pc_out=new_pc and SHALL empty the queue (head=tail, count=0, ready cleared).
REQ-026 While flush_out=1, issue_in and write-backs SHALL be ignored; flush_out SHALL last exactly one cycle.
REQ-027 A correct prediction SHALL cause no flush.
REQ-028 All valid/flush outputs SHALL deassert on every edge without a new event.

Reset
REQ-029 rst SHALL dominate all other inputs and, on that edge, clear head, tail, count and every ready bit, and drive all registered outputs to 0.
REQ-030 rst asserted mid-flush or mid-commit SHALL leave the block empty, with no commit or flush the next cycle.

Configuration
REQ-031 With ROB_DUAL_COMMIT_EN defined, both commit slots SHALL operate per REQ-023; without it, commit1_valid_out SHALL be tied 0 and at most one entry SHALL retire per cycle.

Verification
REQ-032 Reset, then issue 16 entries with no commit -> full_out=1, issue_tag_out=0, and a 17th issue is ignored.
REQ-033 Issue tags 1,2; wb0 tag2 data 0x55, then wb0 tag1 data 0x11 -> commit0 tag1 data 0x11; with DUAL, commit1 tag2 data 0x55 in the same cycle.
REQ-034 Issue BRANCH with predict_pc 0x100, then wb0 new_pc 0x200 -> one cycle with commit0_rf_we=0, flush_out=1, flush_pc_out=0x200; next cycle queue empty, issue_tag_out=head tag.
REQ-035 wb0 and wb1 to tag 3 in the same cycle with data 0xA/0xB -> entry holds 0xA, and qj_tag=3 in that cycle returns ready=1, data 0xA.
REQ-036 Run 40 issue/commit pairs -> tags wrap DEPTH -> 1 with no loss; two adjacent STOREs commit in separate cycles.
